// File: rtl/rom_arbiter_pkg.sv
// Shared definitions for the program-ROM arbiter: port identifiers,
// arbitration mode encodings, pipeline tag type and small helpers.
package rom_arbiter_pkg;

  // Port identifiers used as the owner field of a pipeline tag
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  // Arbitration policy encodings
  localparam int unsigned MODE_RR    = 32'd0;
  localparam int unsigned MODE_FIXED = 32'd1;

  // Starvation-guard wait counter saturates here
  localparam logic [3:0] WAIT_SAT = 4'd15;

  // One in-flight ROM access: did a grant happen, and for which port
  typedef struct packed {
    logic valid;
    logic owner;
  } tag_t;

  // Saturating increment for the 4-bit wait counter
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    logic [3:0] r;
    if (v == WAIT_SAT) begin
      r = v;
    end else begin
      r = v + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rom_arb_core.sv
// Pure grant logic for the two ROM requesters: round-robin pointer,
// fixed-priority starvation guard and the combinational grant decision.
module rom_arb_core
  import rom_arbiter_pkg::*;
#(
  parameter int unsigned MODE     = MODE_RR,
  parameter int unsigned MAX_WAIT = 32'd4
) (
  input  logic clk,
  input  logic reset_b,
  input  logic a_req,
  input  logic b_req,
  output logic a_gnt,
  output logic b_gnt,
  output logic gnt_valid,
  output logic owner
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic       rr_ptr_r;     // port favoured on the next contention
  logic [3:0] wait_cnt_r;   // cycles port B has been refused in a row
  logic       rr_ptr_s;
  logic [3:0] wait_cnt_s;
  logic       a_gnt_s;
  logic       b_gnt_s;

  // Grant decision: at most one grant, never without the matching request
  always_comb begin
    a_gnt_s = 1'b0;
    b_gnt_s = 1'b0;
    if (MODE == MODE_FIXED) begin
      if (b_req && (wait_cnt_r >= MAX_WAIT_C)) begin
        b_gnt_s = 1'b1;
      end else if (a_req) begin
        a_gnt_s = 1'b1;
      end else if (b_req) begin
        b_gnt_s = 1'b1;
      end else begin
        a_gnt_s = 1'b0;
      end
    end else begin
      if (a_req && b_req) begin
        if (rr_ptr_r == PORT_B) begin
          b_gnt_s = 1'b1;
        end else begin
          a_gnt_s = 1'b1;
        end
      end else if (a_req) begin
        a_gnt_s = 1'b1;
      end else if (b_req) begin
        b_gnt_s = 1'b1;
      end else begin
        a_gnt_s = 1'b0;
      end
    end
  end

  // Next pointer and wait count; both hold when nobody is requesting
  always_comb begin
    rr_ptr_s   = rr_ptr_r;
    wait_cnt_s = wait_cnt_r;
    if (a_gnt_s) begin
      rr_ptr_s = PORT_B;
    end else if (b_gnt_s) begin
      rr_ptr_s = PORT_A;
    end else begin
      rr_ptr_s = rr_ptr_r;
    end
    if (MODE != MODE_FIXED) begin
      wait_cnt_s = 4'd0;
    end else if (b_req && !b_gnt_s) begin
      wait_cnt_s = sat_inc4(wait_cnt_r);
    end else if (b_gnt_s || a_req) begin
      wait_cnt_s = 4'd0;
    end else begin
      wait_cnt_s = wait_cnt_r;
    end
  end

  // Arbiter state register
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      rr_ptr_r   <= PORT_A;
      wait_cnt_r <= 4'd0;
    end else begin
      rr_ptr_r   <= rr_ptr_s;
      wait_cnt_r <= wait_cnt_s;
    end
  end

  assign a_gnt     = a_gnt_s;
  assign b_gnt     = b_gnt_s;
  assign gnt_valid = a_gnt_s | b_gnt_s;
  assign owner     = b_gnt_s ? PORT_B : PORT_A;

endmodule

// File: rtl/rom_arbiter.sv
// Shares the single-port program ROM between instruction fetch (A) and
// data/constant load (B). Drives the ROM address for the granted port and
// follows each access through the ROM's registered-address latency with a
// two-stage tag pipeline, returning registered data plus a valid strobe.
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int unsigned MODE     = MODE_RR,
  parameter int unsigned MAX_WAIT = 32'd4,
  parameter int unsigned AW       = 32'd10,
  parameter int unsigned DW       = 32'd32
) (
  input  logic          clk,
  input  logic          reset_b,
  input  logic          a_req,
  input  logic [AW-1:0] a_addr,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic [AW-1:0] b_addr,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic [AW-1:0] rom_address,
  input  logic [DW-1:0] rom_dout
);

  logic          a_gnt_s;
  logic          b_gnt_s;
  logic          gnt_valid_s;
  logic          owner_s;
  tag_t          tag_s1_r;     // access whose data appears on rom_dout now
  logic          a_rvalid_r;
  logic          b_rvalid_r;
  logic [DW-1:0] a_rdata_r;
  logic [DW-1:0] b_rdata_r;

  rom_arb_core #(
    .MODE     (MODE),
    .MAX_WAIT (MAX_WAIT)
  ) u_core (
    .clk       (clk),
    .reset_b   (reset_b),
    .a_req     (a_req),
    .b_req     (b_req),
    .a_gnt     (a_gnt_s),
    .b_gnt     (b_gnt_s),
    .gnt_valid (gnt_valid_s),
    .owner     (owner_s)
  );

  // With no grant the A address is presented; that read is never tagged valid
  assign rom_address = b_gnt_s ? b_addr : a_addr;
  assign a_gnt       = a_gnt_s;
  assign b_gnt       = b_gnt_s;

  // Stage 1: record this cycle's grant alongside the address the ROM latches
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      tag_s1_r <= '0;
    end else begin
      tag_s1_r <= '{valid: gnt_valid_s, owner: owner_s};
    end
  end

  // Stage 2: steer rom_dout to the owning port; data holds between strobes
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      a_rvalid_r <= 1'b0;
      b_rvalid_r <= 1'b0;
      a_rdata_r  <= '0;
      b_rdata_r  <= '0;
    end else begin
      a_rvalid_r <= tag_s1_r.valid && (tag_s1_r.owner == PORT_A);
      b_rvalid_r <= tag_s1_r.valid && (tag_s1_r.owner == PORT_B);
      if (tag_s1_r.valid && (tag_s1_r.owner == PORT_A)) begin
        a_rdata_r <= rom_dout;
      end else begin
        a_rdata_r <= a_rdata_r;
      end
      if (tag_s1_r.valid && (tag_s1_r.owner == PORT_B)) begin
        b_rdata_r <= rom_dout;
      end else begin
        b_rdata_r <= b_rdata_r;
      end
    end
  end

  assign a_rvalid = a_rvalid_r;
  assign b_rvalid = b_rvalid_r;
  assign a_rdata  = a_rdata_r;
  assign b_rdata  = b_rdata_r;

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: a round-robin instance and a fixed-priority
// instance (MAX_WAIT=4), each driving its own ROM model holding
// mem[i] = 32'hA5000000 + i. Expected read returns go into per-port queues
// when grants are checked and are retired when the rvalid strobes arrive.
module tb_rom_arbiter;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_b;
  // round-robin instance
  logic        a_req, b_req, a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [9:0]  a_addr, b_addr, rom_address, rom_q;
  logic [31:0] a_rdata, b_rdata, rom_dout;
  // fixed-priority instance
  logic        fa_req, fb_req, fa_gnt, fb_gnt, fa_rvalid, fb_rvalid;
  logic [9:0]  fa_addr, fb_addr, f_rom_address, f_rom_q;
  logic [31:0] fa_rdata, fb_rdata, f_rom_dout;

  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  exp_t q[4][$];   // 0: rr A, 1: rr B, 2: fixed A, 3: fixed B

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rom_arbiter #(.MODE(0), .MAX_WAIT(4), .AW(10), .DW(32)) u_rr (
    .clk(clk), .reset_b(reset_b),
    .a_req(a_req), .a_addr(a_addr), .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_addr(b_addr), .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .rom_address(rom_address), .rom_dout(rom_dout)
  );

  rom_arbiter #(.MODE(1), .MAX_WAIT(4), .AW(10), .DW(32)) u_fx (
    .clk(clk), .reset_b(reset_b),
    .a_req(fa_req), .a_addr(fa_addr), .a_gnt(fa_gnt), .a_rvalid(fa_rvalid), .a_rdata(fa_rdata),
    .b_req(fb_req), .b_addr(fb_addr), .b_gnt(fb_gnt), .b_rvalid(fb_rvalid), .b_rdata(fb_rdata),
    .rom_address(f_rom_address), .rom_dout(f_rom_dout)
  );

  // ROM models: registered address, combinational content
  always @(posedge clk) begin
    rom_q   <= rom_address;
    f_rom_q <= f_rom_address;
  end
  assign rom_dout   = 32'hA5000000 + {22'd0, rom_q};
  assign f_rom_dout = 32'hA5000000 + {22'd0, f_rom_q};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: check all four grants mid-cycle, queue the expected returns
  task automatic step(input logic eag, input logic ebg, input logic efa, input logic efb);
    exp_t e;
    @(negedge clk);
    chk("rr_a_gnt", {31'd0, a_gnt}, {31'd0, eag});
    chk("rr_b_gnt", {31'd0, b_gnt}, {31'd0, ebg});
    chk("fx_a_gnt", {31'd0, fa_gnt}, {31'd0, efa});
    chk("fx_b_gnt", {31'd0, fb_gnt}, {31'd0, efb});
    e.cyc = cyc + 2;
    if (eag) begin e.data = 32'hA5000000 + {22'd0, a_addr};  q[0].push_back(e); end
    if (ebg) begin e.data = 32'hA5000000 + {22'd0, b_addr};  q[1].push_back(e); end
    if (efa) begin e.data = 32'hA5000000 + {22'd0, fa_addr}; q[2].push_back(e); end
    if (efb) begin e.data = 32'hA5000000 + {22'd0, fb_addr}; q[3].push_back(e); end
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every rvalid must match the oldest expected return, on time
  always @(negedge clk) begin
    logic [3:0]  rv;
    logic [31:0] rd [4];
    exp_t        e;
    rv    = {fb_rvalid, fa_rvalid, b_rvalid, a_rvalid};
    rd[0] = a_rdata;  rd[1] = b_rdata;  rd[2] = fa_rdata;  rd[3] = fb_rdata;
    for (int p = 0; p < 4; p++) begin
      if (rv[p] === 1'b1) begin
        n_assert++;
        assert (q[p].size() > 0) else begin
          n_fail++;
          $error("FAIL rvalid_unexpected[%0d]: observed rvalid=1 at cycle %0d expected rvalid=0", p, cyc);
        end
        if (q[p].size() > 0) begin
          e = q[p].pop_front();
          n_assert++;
          assert ((rd[p] === e.data) && (cyc == e.cyc)) else begin
            n_fail++;
            $error("FAIL rdata[%0d]: observed %h at cycle %0d expected %h at cycle %0d",
                   p, rd[p], cyc, e.data, e.cyc);
          end
        end
      end else if ((q[p].size() > 0) && (q[p][0].cyc <= cyc)) begin
        e = q[p].pop_front();
        n_assert++;
        assert (rv[p] === 1'b1) else begin
          n_fail++;
          $error("FAIL rvalid_missing[%0d]: observed rvalid=%b at cycle %0d expected 1 with %h",
                 p, rv[p], cyc, e.data);
        end
      end
    end
  end

  initial begin
    reset_b = 1'b0;
    a_req = 1'b0; b_req = 1'b0; a_addr = 10'd0; b_addr = 10'd0;
    fa_req = 1'b0; fb_req = 1'b0; fa_addr = 10'd0; fb_addr = 10'd0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_a_rvalid", {31'd0, a_rvalid}, 32'd0);
    chk("rst_b_rvalid", {31'd0, b_rvalid}, 32'd0);
    chk("rst_a_rdata", a_rdata, 32'd0);
    chk("rst_b_rdata", b_rdata, 32'd0);
    chk("rst_fx_rdata", fb_rdata, 32'd0);
    chk("rst_gnt", {30'd0, a_gnt, b_gnt}, 32'd0);
    @(posedge clk); #1;
    reset_b = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // 1: single A access, data two cycles later
    a_req = 1'b1; a_addr = 10'h005;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    a_req = 1'b0;
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_a_rdata_hold", a_rdata, 32'hA5000005);

    // Lone B request leaves the pointer favouring A
    b_req = 1'b1; b_addr = 10'h007;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    b_req = 1'b0;

    // 2: round-robin contention alternates A,B,...
    a_req = 1'b1; b_req = 1'b1; a_addr = 10'h010; b_addr = 10'h020;
    for (int i = 0; i < 6; i++) step((i % 2) == 0, (i % 2) == 1, 1'b0, 1'b0);
    a_req = 1'b0; b_req = 1'b0;
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);

    // 3: back-to-back streaming up to the top of the address space
    a_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_addr = 10'h3F8 + 10'(i);
      step(1'b1, 1'b0, 1'b0, 1'b0);
    end
    a_req = 1'b0;
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);

    // 4: fixed priority with starvation guard: A x4 then B, repeating
    fa_req = 1'b1; fb_req = 1'b1; fa_addr = 10'h100; fb_addr = 10'h200;
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0, (i % 5) != 4, (i % 5) == 4);
    fa_req = 1'b0; fb_req = 1'b0;
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);

    // 5: reset between grants and their data; nothing may come back
    a_req = 1'b1; a_addr = 10'h030;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    a_req = 1'b0; b_req = 1'b1; b_addr = 10'h040;
    @(negedge clk);
    chk("t5_b_gnt", {31'd0, b_gnt}, 32'd1);
    chk("t5_a_gnt", {31'd0, a_gnt}, 32'd0);
    reset_b = 1'b0;
    for (int p = 0; p < 4; p++) q[p].delete();
    b_req = 1'b0;
    @(posedge clk); #1;
    reset_b = 1'b1;
    @(negedge clk);
    chk("t5_a_rdata", a_rdata, 32'd0);
    chk("t5_b_rdata", b_rdata, 32'd0);
    chk("t5_rvalid", {30'd0, a_rvalid, b_rvalid}, 32'd0);
    @(posedge clk); #1;
    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0);

    // 6: traffic, long idle, data held, then B granted at once
    a_req = 1'b1; a_addr = 10'h055;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    a_req = 1'b0; b_req = 1'b1; b_addr = 10'h066;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    b_req = 1'b0;
    repeat (10) step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_a_hold", a_rdata, 32'hA5000055);
    chk("t6_b_hold", b_rdata, 32'hA5000066);
    b_req = 1'b1; b_addr = 10'h3FF;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    a_req = 1'b1; a_addr = 10'h001; b_addr = 10'h002;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    a_req = 1'b0; b_req = 1'b0;
    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0);

    for (int p = 0; p < 4; p++) chk("drain", q[p].size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
Name: rom_arbiter

Overview:
- Shares the single-port 1024x32 program ROM between two requesters:
  - port A: instruction fetch.
  - port B: data/constant load.
- Arbitrates one access per cycle and drives the ROM address.
- Tracks each access through the ROM's one-cycle registered-address latency, then returns registered read data with a per-port valid strobe.
- Sits between the CPU fetch/load units and the ROM instance.

Parameters:
- MODE, 0, arbitration policy. 0 = round-robin. 1 = fixed priority to port A, with starvation guard.
- MAX_WAIT, 4, in MODE 1: consecutive cycles port B may be refused before it gets a forced grant. Legal range 1..15.
- AW, 10, address width; matches ROM depth.
- DW, 32, data width.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset_b  in  1  asynchronous, active-low reset.
- a_req  in  1  port A request; address and request held stable until granted.
- a_addr  in  AW  port A word address.
- a_gnt  out  1  combinational; request accepted this cycle.
- a_rvalid  out  1  registered; a_rdata valid this cycle.
- a_rdata  out  DW  registered read data for port A.
- b_req  in  1  port B request.
- b_addr  in  AW  port B word address.
- b_gnt  out  1  combinational grant for port B.
- b_rvalid  out  1  registered valid for port B.
- b_rdata  out  DW  registered read data for port B.
- rom_address  out  AW  combinational address to the ROM.
- rom_dout  in  DW  ROM data; reflects the address captured at the previous rising edge.

Behaviour:
- Reset (asynchronous, reset_b low):
  - a_rvalid, b_rvalid = 0.
  - a_rdata, b_rdata = 0.
  - Round-robin pointer = port A.
  - Wait counter = 0.
  - Both pipeline tags invalid.
- Grant outputs are combinational from the current state and inputs, so they are effectively 0 while reset_b is low.
- At most one grant per cycle. The grant is combinational from req and the arbiter state, and is never asserted without the matching req.
- rom_address = granted port's address. With no grant it shows a_addr; the result of that read is discarded.
- Pipeline and latency:
  - Grant in cycle N: ROM latches the address at the end of N.
  - rom_dout is valid in N+1. The tag pipeline captures it into x_rdata at the end of N+1.
  - x_rvalid is high for exactly one cycle, N+2. Read latency is 2 cycles from grant.
  - Fully pipelined: back-to-back grants give back-to-back rvalids, in order.
- x_rdata holds its last value while x_rvalid is low.
- Tag pipeline:
  - Stage 1: {valid, owner} written every cycle from the grant.
  - Stage 2: the rdata/rvalid register update.
- Round-robin (MODE 0):
  - Only one port requesting: that port is granted.
  - Both requesting: the port not granted last is granted. The pointer updates only on a grant.
  - Simultaneous first requests after reset: port A wins.
- Fixed priority (MODE 1):
  - Port A wins contention.
  - The wait counter increments each cycle b_req is high and b_gnt is low, saturating at 15. It clears when b is granted or b_req is low.
  - When wait counter >= MAX_WAIT and b_req is high, port B is granted regardless of a_req.
- The counter and pointer are unaffected when neither port requests.
- If reset_b asserts mid-operation, in-flight tags are discarded. No rvalid may appear after release for pre-reset grants.
- The ROM's internal address register is not reset; correctness relies only on the tags.
- No address range checking: AW bits index all 1024 words, so address wrap is inherent.

Decomposition:
- Shared package holds:
  - Port ID constants: PORT_A = 1'b0, PORT_B = 1'b1.
  - MODE encodings: MODE_RR = 0, MODE_FIXED = 1.
  - A tag struct {valid, owner}.
- One natural sub-module: rom_arb_core. It holds the pure grant logic, pointer and wait counter, and outputs gnt plus owner.
- The top level adds the address mux and the 2-stage tag/data pipeline.
- Bench instantiates rom_arbiter plus the ROM loaded with mem[i] = 32'hA5000000 + i.

Test Plan:
1. Reset and single port:
   - Stimulus: reset_b low mid-stream then released. After release, a_req=1 with a_addr=10'h005 for 1 cycle.
   - Response: a_gnt same cycle; a_rvalid exactly 2 cycles later with a_rdata = 32'hA5000005; b_rvalid stays 0.
2. Round-robin contention, MODE 0:
   - Stimulus: a_req and b_req held high for 6 cycles with a_addr=0x010, b_addr=0x020.
   - Response: grants alternate A,B,A,B,A,B. rvalids alternate 2 cycles later with data 0xA5000010 / 0xA5000020. No cycle has both gnt.
3. Back-to-back streaming:
   - Stimulus: a_req high for 8 cycles, a_addr incrementing 0x3F8..0x3FF, no B requests.
   - Response: 8 consecutive a_rvalid cycles with data 0xA50003F8..0xA50003FF, in order.
4. Starvation guard, MODE 1, MAX_WAIT=4:
   - Stimulus: a_req and b_req held high.
   - Response: A granted 4 cycles, B granted on cycle 5, then A for 4 cycles again. The pattern repeats.
5. Reset mid-flight:
   - Stimulus: grant A and B on consecutive cycles, then pulse reset_b low for 1 cycle before the rvalids.
   - Response: neither a_rvalid nor b_rvalid ever asserts for those grants; rdata = 0 after reset.
6. Idle:
   - Stimulus: no req for 10 cycles after traffic.
   - Response: no gnt, no rvalid, rdata holds last value, pointer/counter unchanged. The next single B request is granted immediately.
